// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller time-sharing one full_adder
module full_adder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);
    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rs;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             s_bit;
    logic             c_bit;

    full_adder u_fa (
        .A   (ra[0]),
        .B   (rb[0]),
        .Cin (c),
        .S   (s_bit),
        .Cout(c_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            rs    <= '0;
            c     <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        ra    <= a;
                        rb    <= b;
                        c     <= cin;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    rs  <= {s_bit, rs[WIDTH-1:1]};
                    c   <= c_bit;
                    cnt <= cnt + CW'(1);
                    // Current count WIDTH-1 means this edge is the final shift
                    if (cnt == CW'(WIDTH - 1))
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign sum  = rs;
    assign cout = c;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start4, cin4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
    } vec_t;

    vec_t vecs[6];

    // One 8-bit operation; done must appear after edge E+8 and last one cycle
    task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                           input logic [7:0] es, input logic eco, input string name);
        int n;
        a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        chk({name, " busy_after_accept"}, 32'(busy8), 1);
        n = 0;
        while (!done8 && n < 30) begin
            tick;
            n++;
        end
        chk({name, " latency"}, n, 8);
        chk({name, " sum"}, 32'(sum8), 32'(es));
        chk({name, " cout"}, 32'(cout8), 32'(eco));
        tick;
        chk({name, " done_one_cycle"}, 32'(done8), 0);
        chk({name, " busy_cleared"}, 32'(busy8), 0);
    endtask

    initial begin
        int n, dn, bc, k, last;
        logic [8:0] tot;
        logic [4:0] tot4;
        logic [7:0] ra, rb, cap_s;
        logic       rc, cap_c;
        logic [7:0] pa[2];
        logic [7:0] ps[2];
        logic       pc[2];

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        #12;
        chk("reset busy", 32'(busy8), 0);
        chk("reset done", 32'(done8), 0);
        chk("reset sum", 32'(sum8), 0);
        chk("reset cout", 32'(cout8), 0);

        // Reset released while start is high: accepted at the first edge
        a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
        #1 rst = 1'b0;
        tick;
        start8 = 1'b0;
        chk("rel_start busy", 32'(busy8), 1);
        n = 0;
        while (!done8 && n < 30) begin
            tick;
            n++;
        end
        chk("rel_start latency", n, 8);
        chk("rel_start sum", 32'(sum8), 32'h96);
        chk("rel_start cout", 32'(cout8), 0);
        tick;

        foreach (vecs[i])
            run_op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].s, vecs[i].co,
                    $sformatf("vec%0d", i));

        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            tot = {1'b0, ra} + {1'b0, rb} + {8'b0, rc};
            run_op8(ra, rb, rc, tot[7:0], tot[8], $sformatf("rand%0d", i));
        end

        // Exhaustive 4-bit sweep with busy width measured per operation
        for (int i = 0; i < 512; i++) begin
            a4 = 4'(i); b4 = 4'(i >> 4); cin4 = 1'(i >> 8);
            tot4 = {1'b0, a4} + {1'b0, b4} + {4'b0, cin4};
            start4 = 1'b1;
            tick;
            start4 = 1'b0;
            bc = 0; dn = 0; cap_s = '0; cap_c = 1'b0;
            while (busy4 && bc < 20) begin
                bc++;
                if (done4) begin
                    dn++;
                    cap_s = {4'b0, sum4};
                    cap_c = cout4;
                end
                tick;
            end
            chk($sformatf("w4 %0d busy_cycles", i), bc, 5);
            chk($sformatf("w4 %0d dones", i), dn, 1);
            chk($sformatf("w4 %0d result", i), {cap_c, cap_s[3:0]}, 32'(tot4));
        end

        // start pulse and operand changes during SHIFT are ignored
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        tick; tick; tick;
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        dn = 0; cap_s = '0; cap_c = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (done8) begin
                dn++;
                cap_s = sum8;
                cap_c = cout8;
            end
            tick;
        end
        chk("inflight dones", dn, 1);
        chk("inflight sum", 32'(cap_s), 32'h47);
        chk("inflight cout", 32'(cap_c), 0);
        chk("inflight idle", 32'(busy8), 0);

        // Reset between edges three cycles into SHIFT
        a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b0; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        tick; tick; tick;
        chk("midrst sum_nonzero_before", 32'(sum8 != 8'h00), 1);
        #3 rst = 1'b1;
        #1;
        chk("midrst busy", 32'(busy8), 0);
        chk("midrst sum", 32'(sum8), 0);
        chk("midrst cout", 32'(cout8), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            if (done8) dn++;
            tick;
        end
        chk("midrst no_done", dn, 0);

        // start held high: alternating operands, one done every 10 cycles
        pa[0] = 8'h01; ps[0] = 8'h02; pc[0] = 1'b0;
        pa[1] = 8'h80; ps[1] = 8'h00; pc[1] = 1'b1;
        a8 = pa[0]; b8 = pa[0]; cin8 = 1'b0; start8 = 1'b1;
        k = 0; last = 0; n = 0;
        while (k < 4 && n < 80) begin
            tick;
            n++;
            if (done8) begin
                chk($sformatf("b2b%0d sum", k), 32'(sum8), 32'(ps[k % 2]));
                chk($sformatf("b2b%0d cout", k), 32'(cout8), 32'(pc[k % 2]));
                if (k > 0) chk($sformatf("b2b%0d interval", k), n - last, 10);
                last = n;
                k++;
                a8 = pa[k % 2]; b8 = pa[k % 2];
            end
        end
        chk("b2b done_count", k, 4);
        start8 = 1'b0;
        n = 0;
        while (busy8 && n < 30) begin
            tick;
            n++;
        end
        chk("b2b drained", 32'(busy8), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
